// File: rtl/fetch_queue.sv
// In-order fetch queue between the I-cache response path and decode, with credit flow and flush drop.
// Optional same-cycle bypass of an empty queue: define FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush_i,
  output logic                         ireq_ready_o,
  input  logic                         ireq_fire_i,
  input  logic                         iresp_valid_i,
  input  logic [31:0]                  iresp_pc_i,
  input  logic [31:0]                  iresp_instr_i,
  input  logic                         iresp_adel_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_pc_o,
  output logic [31:0]                  out_instr_o,
  output logic                         out_adel_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [64:0]   mem_q [DEPTH];
  logic [64:0]   head_entry;
  logic          fire_ok, resp_ok, live_resp, bypass, push, pop;

  // Credit check, response classification and head/bypass output selection.
  always_comb begin
    ireq_ready_o = !flush_i &&
                   (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
    fire_ok      = ireq_fire_i && ireq_ready_o;
    // A response with nothing outstanding or being dropped is a protocol error and is ignored.
    resp_ok      = iresp_valid_i && ((inflight_q != {CW{1'b0}}) || (drop_q != {CW{1'b0}}));
    live_resp    = resp_ok && (drop_q == {CW{1'b0}}) && !flush_i;
`ifdef FETCHQ_BYPASS_EN
    bypass       = live_resp && (count_q == {CW{1'b0}});
`else
    bypass       = 1'b0;
`endif
    head_entry   = mem_q[head_q];
    out_valid_o  = ((count_q != {CW{1'b0}}) && !flush_i) || bypass;
    if (bypass) begin
      out_pc_o    = iresp_pc_i;
      out_instr_o = iresp_instr_i;
      out_adel_o  = iresp_adel_i;
    end else begin
      out_pc_o    = head_entry[64:33];
      out_instr_o = head_entry[32:1];
      out_adel_o  = head_entry[0];
    end
    pop     = (count_q != {CW{1'b0}}) && !flush_i && out_ready_i;
    push    = live_resp && !(bypass && out_ready_i);
    count_o = count_q;
  end

  // Next-state for pointers, occupancy, outstanding credits and stale-drop counter.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (flush_i) begin
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      inflight_d = {CW{1'b0}};
      // Everything outstanding becomes stale; a response arriving now already settles one.
      drop_d     = drop_q + inflight_q + {{(CW-1){1'b0}}, fire_ok} - {{(CW-1){1'b0}}, resp_ok};
    end else begin
      head_d     = pop  ? head_q + {{(PW-1){1'b0}}, 1'b1} : head_q;
      tail_d     = push ? tail_q + {{(PW-1){1'b0}}, 1'b1} : tail_q;
      count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      inflight_d = inflight_q + {{(CW-1){1'b0}}, fire_ok} - {{(CW-1){1'b0}}, live_resp};
      if (resp_ok && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      inflight_q <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {iresp_pc_i, iresp_instr_i, iresp_adel_i};
    end
  end

  fetch_queue_chk u_chk (
    .clk           (clk),
    .resetn        (resetn),
    .ireq_fire_i   (ireq_fire_i),
    .ireq_ready_i  (ireq_ready_o),
    .iresp_valid_i (iresp_valid_i),
    .idle_i        ((inflight_q == {CW{1'b0}}) && (drop_q == {CW{1'b0}}))
  );
endmodule

// Protocol checks for the IF side of the fetch queue.
module fetch_queue_chk (
  input logic clk,
  input logic resetn,
  input logic ireq_fire_i,
  input logic ireq_ready_i,
  input logic iresp_valid_i,
  input logic idle_i
);
  // Flag requests without credit and responses with nothing outstanding.
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(ireq_fire_i && !ireq_ready_i))
        else $error("fetch_queue: ireq_fire_i without ireq_ready_o");
      assert (!(iresp_valid_i && idle_i))
        else $error("fetch_queue: iresp_valid_i with no request outstanding");
    end
  end
endmodule
